// File: rtl/audio_pkg.sv
// Shared audio definitions for the I2S transmit path (and a future receiver).
//   AUDIO_DATA_W : default sample width per channel
//   AUDIO_SLOT_W : default number of bit-clock periods per channel slot
//   stereo_t     : one left/right sample pair, two's complement
package audio_pkg;

    localparam int AUDIO_DATA_W = 16;
    localparam int AUDIO_SLOT_W = 16;

    typedef struct packed {
        logic signed [AUDIO_DATA_W-1:0] left;
        logic signed [AUDIO_DATA_W-1:0] right;
    } stereo_t;

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Sample-pair handshake between an audio source and the I2S transmitter.
//   s_valid : source has a left/right pair on s_left/s_right
//   s_ready : transmitter holding register is empty
//   s_left  : left sample, two's complement
//   s_right : right sample, two's complement
// A pair transfers on a clock edge where s_valid and s_ready are both high.
// Modports: master = sample source, slave = transmitter.
interface i2s_tx_serializer_if
    import audio_pkg::*;
#(
    parameter int DATA_W = AUDIO_DATA_W
);

    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_left;
    logic signed [DATA_W-1:0] s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );

endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk down to bclk and flags the cycle in which
// bclk is about to change, so downstream logic can update in lock-step with
// the bclk edge.
//   clk      : system clock
//   rst      : asynchronous active-high reset (bclk low, divider cleared)
//   bclk     : registered bit clock, period 2*BCLK_DIV clk cycles
//   fall_evt : high in the clk cycle whose closing edge takes bclk 1->0
//   rise_evt : high in the clk cycle whose closing edge takes bclk 0->1
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic fall_evt,
    output logic rise_evt
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap     = (div_cnt == DIV_MAX);
    assign fall_evt = wrap & bclk;
    assign rise_evt = wrap & ~bclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo I2S transmitter. Takes left/right pairs over a valid/ready handshake
// into a one-deep holding register and shifts each frame out MSB-first in
// standard I2S format: sdata changes on the bclk falling edge and the channel
// MSB follows each lrclk transition by one bit.
//   clk, rst  : system clock, asynchronous active-high reset
//   s         : sample handshake (slave side of i2s_tx_serializer_if)
//   bclk      : serial bit clock, period 2*BCLK_DIV clk
//   lrclk     : word select, 0 = left slot, 1 = right slot
//   sdata     : serial data
//   underrun  : one-clk pulse when a frame starts with no pair pending
// Optional build macro I2S_TX_UNDERRUN_REPEAT_EN: an underrun frame resends
// the last transmitted pair instead of silence.
module i2s_tx_serializer
    import audio_pkg::*;
#(
    parameter int DATA_W   = AUDIO_DATA_W,
    parameter int SLOT_W   = AUDIO_SLOT_W,
    parameter int BCLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    i2s_tx_serializer_if.slave   s,
    output logic                 bclk,
    output logic                 lrclk,
    output logic                 sdata,
    output logic                 underrun
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LR_LO   = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] LR_HI   = CNT_W'(FRAME_W - 2);

    // Left-justify a sample inside its slot; unused LSBs transmit as zero.
    function automatic logic [SLOT_W-1:0] pad_slot(input logic signed [DATA_W-1:0] smp);
        logic [SLOT_W-1:0] w;
        w = SLOT_W'($unsigned(smp));
        return w << (SLOT_W - DATA_W);
    endfunction

    logic                     fall_evt;
    logic                     bclk_rise_unused;
    logic [CNT_W-1:0]         bit_cnt;
    logic [CNT_W-1:0]         bit_nxt;
    logic                     lr_nxt;
    logic                     frame_start;
    logic                     full;
    logic                     accept;
    logic signed [DATA_W-1:0] hold_left;
    logic signed [DATA_W-1:0] hold_right;
    logic [FRAME_W-1:0]       shift;
    logic [FRAME_W-1:0]       fill_word;
    logic [FRAME_W-1:0]       load_word;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .rst      (rst),
        .bclk     (bclk),
        .fall_evt (fall_evt),
        .rise_evt (bclk_rise_unused)
    );

    assign s.s_ready   = ~full;
    assign accept      = s.s_valid & ~full;
    assign bit_nxt     = (bit_cnt == CNT_MAX) ? '0 : bit_cnt + 1'b1;
    // lrclk leads the slot by one bit: it switches while the last bit of
    // the previous slot is still on the wire.
    assign lr_nxt      = (bit_nxt >= LR_LO) && (bit_nxt <= LR_HI);
    assign frame_start = fall_evt && (bit_cnt == CNT_MAX);

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    logic [FRAME_W-1:0] copy_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            copy_word <= '0;
        end else if (frame_start && full) begin
            copy_word <= load_word;
        end
    end

    assign fill_word = copy_word;
`else
    assign fill_word = '0;
`endif

    // The frame load looks at the holding register as it was before this
    // edge, so a pair accepted on the load edge waits for the next frame.
    always_comb begin
        load_word = fill_word;
        if (full) begin
            load_word = {pad_slot(hold_left), pad_slot(hold_right)};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_left  <= s.s_left;
            hold_right <= s.s_right;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            bit_cnt  <= CNT_MAX;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            shift    <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= frame_start & ~full;

            if (accept) begin
                full <= 1'b1;
            end else if (frame_start) begin
                full <= 1'b0;
            end

            if (fall_evt) begin
                bit_cnt <= bit_nxt;
                lrclk   <= lr_nxt;
                if (frame_start) begin
                    // Left MSB goes straight to sdata; the rest queues up.
                    sdata <= load_word[FRAME_W-1];
                    shift <= load_word << 1;
                end else begin
                    sdata <= shift[FRAME_W-1];
                    shift <= shift << 1;
                end
            end
        end
    end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Stereo audio transmitter: accepts parallel left/right sample pairs over a valid/ready handshake.
- Generates BCLK and LRCLK internally from the system clock.
- Shifts samples out MSB-first in standard I2S format: data changes on the BCLK falling edge, with a one-bit delay after each LRCLK transition.
- Drives the external DAC; it is the output end of the audio clock/serial path.

Parameters:
- DATA_W, 16, sample width per channel; must satisfy DATA_W <= SLOT_W.
- SLOT_W, 16, BCLK periods per channel slot. Frame length is 2*SLOT_W bits.
- BCLK_DIV, 2, clk cycles per BCLK half-period; must be >= 1. BCLK period is 2*BCLK_DIV clk cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  sample pair valid
- s_ready  out  1  holding register empty; pair accepted when s_valid & s_ready
- s_left  in  DATA_W  left sample, two's complement
- s_right  in  DATA_W  right sample, two's complement
- bclk  out  1  serial bit clock
- lrclk  out  1  word select; 0 = left, 1 = right
- sdata  out  1  serial data
- underrun  out  1  one-clk pulse when a frame starts with no sample pending

Behaviour:
- Interface: one clock `clk`. Reset `rst` is asynchronous and active-high. All state is on the rising edge of clk.
- Reset values: bclk=0, lrclk=0, sdata=0, s_ready=1, underrun=0, div_cnt=0, bit_cnt=2*SLOT_W-1, holding register empty, shift register 0.
- Divider: div_cnt counts 0..BCLK_DIV-1. On wrap, bclk toggles.
  - "Fall event" = the clk cycle in which bclk toggles 1->0.
  - "Rise event" = the clk cycle in which bclk toggles 0->1.
- On each fall event:
  - bit_cnt increments modulo 2*SLOT_W.
  - sdata takes the next shift-register MSB; the shift register moves left by one.
- Frame start is the fall event where bit_cnt wraps to 0:
  - If the holding register is full: the shift register loads {left padded with SLOT_W-DATA_W zero LSBs, right padded likewise}; the holding register clears; sdata = left MSB in that same cycle.
  - If the holding register is empty: the shift register loads all zeros; underrun pulses high for that one clk cycle.
- LRCLK is updated on fall events only:
  - lrclk = 1 while the new bit_cnt is in [SLOT_W-1, 2*SLOT_W-2], else 0.
  - This places each LRCLK transition one bit before the channel MSB (I2S delay).
- Handshake:
  - s_ready = holding register empty.
  - An accept captures s_left and s_right into the holding register.
  - Accept and frame-start load in the same cycle: the load sees the old (empty) state, so the frame underruns. The accepted pair is held for the next frame and s_ready drops the following cycle.
  - s_valid with s_ready=0 is ignored; the sample is not lost, because the source must hold it.
- Latency: a pair accepted while the holding register is empty appears on sdata at the next frame start. With defaults, the worst case is 128 clk after accept.
- Reset mid-frame: all outputs return to reset values immediately. The pending sample is discarded. The first fall event after reset release is a frame start.
- Outputs are registered; no combinational path from inputs to bclk, lrclk or sdata.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_REPEAT_EN.
- Defined: on an underrun, the shift register reloads the last transmitted pair (held in a copy register, reset 0) instead of zeros. underrun still pulses.
- Undefined: underrun frames transmit zeros; no copy register is synthesized.

Decomposition:
- Shared package (audio_pkg):
  - default constants AUDIO_DATA_W=16, AUDIO_SLOT_W=16;
  - typedef for a stereo sample pair struct {left, right}.
- One natural sub-module, i2s_bclk_gen: divider producing bclk plus one-cycle fall_evt/rise_evt strobes. It is reusable by a future I2S receiver.
- Shifter, holding register and frame counter stay in the top module.

Test Plan (defaults: DATA_W=16, SLOT_W=16, BCLK_DIV=2):
1. Reset, then idle with s_valid=0 -> bclk period 4 clk; lrclk period 128 clk, high for 64; sdata=0; underrun pulses once every 128 clk.
2. Accept left=0xA5C3, right=0x0F01 before a frame start -> left slot bits MSB-first 1010010111000011, first bit on the fall event after lrclk falls; right slot 0000111100000001, following the lrclk rise by one bit.
3. Back-to-back pairs with s_valid held high -> s_ready low between accept and the next frame start; no underrun; every pair appears exactly once and in order.
4. s_valid asserted exactly in the frame-start load cycle -> that frame transmits zeros with underrun=1; the pair appears in the next frame.
5. Assert rst mid-right-slot -> bclk, lrclk and sdata are 0 and s_ready is 1 in the same cycle. After release, the first frame starts on the first fall event, and a previously accepted sample is not transmitted.
6. With I2S_TX_UNDERRUN_REPEAT_EN: send 0x1234/0x5678, then stop -> the next frame repeats 0x1234/0x5678 with underrun=1. Without the macro, the next frame is zeros.
